// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory bridge.
package slc3_mem_pkg;

  // Bridge controller states
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } mem_state_t;

  localparam int DW_DEFAULT = 16;
  localparam int RD_LAT_MAX = 7;

  // Value of the 3-bit latency counter on the final READ cycle
  function automatic logic [2:0] lat_last(input int rd_lat);
    return 3'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mem_init_loader.sv
// Post-reset copier: walks the init ROM and produces an aligned RAM write port.
module mem_init_loader
  import slc3_mem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = DW_DEFAULT,
  parameter int INIT_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          last,
  output logic          done
);

  localparam int CW = $clog2(INIT_WORDS + 1);
  localparam logic [CW-1:0] INIT_CNT = CW'(INIT_WORDS);

  logic [CW-1:0] cnt_r;
  logic [AW-1:0] rom_addr_r;
  logic [AW-1:0] wr_addr_r;
  logic          wr_en_r;
  logic          done_r;
  logic          last_s;

  // The final write is in flight once every ROM word has been requested
  assign last_s   = wr_en_r & (cnt_r == INIT_CNT);

  assign rom_addr = rom_addr_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  // ROM data arrives one cycle after its address, i.e. alongside wr_addr_r
  assign wr_data  = rom_data;
  assign last     = last_s;
  assign done     = done_r;

  // Issue ROM reads and trail them by one cycle with the matching RAM write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      rom_addr_r <= '0;
      wr_addr_r  <= '0;
      wr_en_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (cnt_r < INIT_CNT) begin
        cnt_r      <= cnt_r + CW'(1);
        rom_addr_r <= rom_addr_r + AW'(1);
        wr_addr_r  <= rom_addr_r;
        wr_en_r    <= 1'b1;
      end else begin
        wr_en_r    <= 1'b0;
      end
      if (last_s) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

endmodule

// File: rtl/slc3_mem_bridge.sv
// Bridge between the SLC-3 SRAM-style strobes and a synchronous on-chip RAM.
module slc3_mem_bridge
  import slc3_mem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = DW_DEFAULT,
  parameter int RD_LAT     = 2,
  parameter int INIT_WORDS = 256
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [15:0]   ADDR,
  input  logic          OE_n,
  input  logic          WE_n,
  input  logic [DW-1:0] Data_to_SRAM,
  output logic [DW-1:0] Data_from_SRAM,
  output logic          Ready,
  output logic          Busy,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LAST = lat_last(RD_LAT);

  mem_state_t    state_r;
  logic          we_n_q_r;
  logic          wr_pend_r;
  logic [AW-1:0] wr_addr_r;
  logic [DW-1:0] wr_data_r;
  logic [AW-1:0] op_addr_r;
  logic [DW-1:0] op_data_r;
  logic [AW-1:0] last_addr_r;
  logic          valid_r;
  logic [2:0]    lat_cnt_r;
  logic [DW-1:0] rd_data_r;

  logic [AW-1:0] cpu_addr_s;
  logic          wr_evt_s;
  logic          rd_req_s;
  logic [AW-1:0] ld_addr_s;
  logic [DW-1:0] ld_wdata_s;
  logic          ld_we_s;
  logic          ld_last_s;
  logic          ld_done_s;
  logic          addr_hi_unused_s;

  mem_init_loader #(
    .AW         (AW),
    .DW         (DW),
    .INIT_WORDS (INIT_WORDS)
  ) u_loader (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .wr_en    (ld_we_s),
    .wr_addr  (ld_addr_s),
    .wr_data  (ld_wdata_s),
    .last     (ld_last_s),
    .done     (ld_done_s)
  );

  // Upper CPU address bits alias onto the RAM and are deliberately dropped
  assign cpu_addr_s       = ADDR[AW-1:0];
  assign addr_hi_unused_s = ^ADDR;

  // One write event per WE_n falling edge; strobes are ignored while copying
  assign wr_evt_s = we_n_q_r & ~WE_n & (state_r != S_INIT);
  // Reads only with WE_n released, and only when the held data is stale
  assign rd_req_s = ~OE_n & WE_n & (~valid_r | (cpu_addr_s != last_addr_r));

  assign Data_from_SRAM = rd_data_r;
  assign Ready          = ld_done_s;
  assign Busy           = (state_r != S_IDLE) | wr_pend_r;

  // RAM port: loader owns it during INIT, the controller afterwards
  always_comb begin
    mem_addr  = cpu_addr_s;
    mem_wdata = op_data_r;
    mem_we    = 1'b0;
    case (state_r)
      S_INIT: begin
        mem_addr  = ld_addr_s;
        mem_wdata = ld_wdata_s;
        mem_we    = ld_we_s;
      end
      S_WRITE: begin
        mem_addr  = op_addr_r;
        mem_we    = 1'b1;
      end
      S_READ: begin
        mem_addr  = last_addr_r;
      end
      S_IDLE: begin
        mem_addr  = cpu_addr_s;
      end
      default: begin
        mem_addr  = cpu_addr_s;
      end
    endcase
  end

  // Controller FSM, write-edge capture and read-data register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= S_INIT;
      we_n_q_r    <= 1'b1;
      wr_pend_r   <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      op_addr_r   <= '0;
      op_data_r   <= '0;
      last_addr_r <= '0;
      valid_r     <= 1'b0;
      lat_cnt_r   <= 3'd0;
      rd_data_r   <= '0;
    end else begin
      we_n_q_r <= WE_n;
      case (state_r)
        S_INIT: begin
          if (ld_last_s) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_INIT;
          end
        end
        S_IDLE: begin
          if (wr_pend_r) begin
            // Snapshot so a newer capture cannot disturb the write in flight
            op_addr_r <= wr_addr_r;
            op_data_r <= wr_data_r;
            wr_pend_r <= 1'b0;
            valid_r   <= 1'b0;
            state_r   <= S_WRITE;
          end else if (rd_req_s) begin
            last_addr_r <= cpu_addr_s;
            lat_cnt_r   <= 3'd0;
            state_r     <= S_READ;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_READ: begin
          if (lat_cnt_r == LAT_LAST) begin
            rd_data_r <= mem_rdata;
            valid_r   <= 1'b1;
            state_r   <= S_IDLE;
          end else begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        S_WRITE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
      // Placed last so a fresh capture wins over the clear in S_IDLE
      if (wr_evt_s) begin
        wr_pend_r <= 1'b1;
        wr_addr_r <= cpu_addr_s;
        wr_data_r <= Data_to_SRAM;
      end
    end
  end

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Directed bench for slc3_mem_bridge with a behavioural ROM and 2-cycle RAM.
module tb_slc3_mem_bridge;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] ADDR;
  logic        OE_n;
  logic        WE_n;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        Ready;
  logic        Busy;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [15:0] ram [0:1023];
  logic [15:0] rd_p1;
  logic [15:0] rd_p2;
  logic [15:0] we_cnt = 16'd0;
  logic [15:0] base;
  logic [9:0]  last_wa;
  logic [15:0] last_wd;
  logic [15:0] init_idx = 16'd0;
  logic [15:0] order_err = 16'd0;
  int          n;

  slc3_mem_bridge dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .ADDR           (ADDR),
    .OE_n           (OE_n),
    .WE_n           (WE_n),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .Ready          (Ready),
    .Busy           (Busy),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM image A000+i, RAM with two-cycle read pipeline, write monitor
  always @(posedge Clk) begin
    rom_data <= 16'hA000 + {6'd0, rom_addr};
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt  <= we_cnt + 16'd1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
    rd_p1 <= ram[mem_addr];
    rd_p2 <= rd_p1;
    if (!Reset_n) begin
      init_idx  <= 16'd0;
      order_err <= 16'd0;
    end else if (mem_we && !Ready) begin
      if (mem_addr != init_idx[9:0] || mem_wdata != 16'hA000 + init_idx)
        order_err <= order_err + 16'd1;
      init_idx <= init_idx + 16'd1;
    end
  end
  assign mem_rdata = rd_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(Data_from_SRAM), 32'h0);
    check({tag, "_ready"}, 32'(Ready), 32'h0);
    check({tag, "_busy"},  32'(Busy), 32'h1);
    check({tag, "_we"},    32'(mem_we), 32'h0);
    check({tag, "_maddr"}, 32'(mem_addr), 32'h0);
    check({tag, "_raddr"}, 32'(rom_addr), 32'h0);
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!Ready && n < 400) begin
      step(1);
      n++;
    end
    check({tag, "_ready_cycle"}, 32'(n), 32'd257);
    check({tag, "_init_writes"}, 32'(init_idx), 32'd256);
    check({tag, "_init_order"},  32'(order_err), 32'd0);
  endtask

  initial begin
    rom_data     = 16'h0000;
    Reset_n      = 1'b1;
    ADDR         = 16'h0000;
    OE_n         = 1'b1;
    WE_n         = 1'b1;
    Data_to_SRAM = 16'h0000;
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("reset");

    // 1: init copy
    step(2);
    Reset_n = 1'b1;
    wait_ready("init");
    check("ram_0",   32'(ram[0]),   32'hA000);
    check("ram_255", 32'(ram[255]), 32'hA0FF);

    // 2: read 0x10, three-edge latency, no repeat reads while held
    ADDR = 16'h0010;
    OE_n = 1'b0;
    step(2);
    check("rd_early", 32'(Data_from_SRAM), 32'h0);
    step(1);
    check("rd_0x10", 32'(Data_from_SRAM), 32'hA010);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (Busy) n++;
    end
    check("rd_hold_busy", 32'(n), 32'd0);

    // 3: long WE_n assertion yields a single write
    OE_n = 1'b1;
    base = we_cnt;
    ADDR = 16'h0020;
    Data_to_SRAM = 16'h1234;
    WE_n = 1'b0;
    step(5);
    WE_n = 1'b1;
    step(3);
    check("wr_pulses", 32'(we_cnt - base), 32'd1);
    check("wr_addr",   32'(last_wa), 32'h20);
    check("wr_data",   32'(last_wd), 32'h1234);
    OE_n = 1'b0;
    step(3);
    check("rd_0x20", 32'(Data_from_SRAM), 32'h1234);

    // 4: write arrives during a read of the same address
    OE_n = 1'b1;
    step(1);
    ADDR = 16'h0010;
    OE_n = 1'b0;
    step(1);
    check("coll_busy", 32'(Busy), 32'h1);
    Data_to_SRAM = 16'h5A5A;
    WE_n = 1'b0;
    step(2);
    check("coll_rd_old", 32'(Data_from_SRAM), 32'hA010);
    step(1);
    check("coll_we",    32'(mem_we), 32'h1);
    check("coll_waddr", 32'(mem_addr), 32'h10);
    WE_n = 1'b1;
    step(4);
    check("coll_rd_new", 32'(Data_from_SRAM), 32'h5A5A);

    // 5: both strobes low
    OE_n = 1'b1;
    step(1);
    base = we_cnt;
    ADDR = 16'h0030;
    Data_to_SRAM = 16'hBEEF;
    OE_n = 1'b0;
    WE_n = 1'b0;
    step(6);
    check("both_pulses", 32'(we_cnt - base), 32'd1);
    check("both_waddr",  32'(last_wa), 32'h30);
    check("both_wdata",  32'(last_wd), 32'hBEEF);
    check("both_busy",   32'(Busy), 32'h0);
    check("both_nord",   32'(Data_from_SRAM), 32'h5A5A);
    WE_n = 1'b1;
    step(3);
    check("rd_0x30", 32'(Data_from_SRAM), 32'hBEEF);

    // 6: async reset in the middle of the copy, then aliasing read
    OE_n = 1'b1;
    Reset_n = 1'b0;
    step(2);
    Reset_n = 1'b1;
    step(100);
    check("mid_rom_addr", 32'(rom_addr), 32'd100);
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    step(2);
    Reset_n = 1'b1;
    wait_ready("reinit");
    ADDR = 16'hFC10;
    OE_n = 1'b0;
    step(3);
    check("alias_rd", 32'(Data_from_SRAM), 32'hA010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
